lane_interleaver: RTL and testbench

- Parametrised single-clock successor to the fixed 4-to-1, multi-clock lane mux tree.
- Captures one frame: one word from each of N_LANES parallel lanes, each with its own valid.
- Serialises the frame onto one DATA_WIDTH output stream, emitted in lane order.
- Adds two things the fixed tree lacks: valid/ready backpressure on both sides, and a compact mode that skips invalid lanes instead of emitting idle slots.
- Sits between the lane-parallel datapath and the single-lane serial stage.

---
 rtl/lane_interleaver.sv | 88 ++++++++
 tb/tb_lane_interleaver.sv | 130 +++++++++++++
 2 files changed

// File: rtl/lane_interleaver.sv
// lane_interleaver: captures one N_LANES-wide frame and serialises it in lane order,
// with valid/ready handshakes on both sides and an optional compact (skip invalid) mode.
module lane_interleaver #(
    parameter int DATA_WIDTH = 8,
    parameter int N_LANES    = 4,
    parameter int LANE_W     = $clog2(N_LANES)
) (
    input  logic                          clk,
    input  logic                          reset_L,
    input  logic                          mode_compact,
    input  logic [N_LANES-1:0]            valid_in,
    input  logic [N_LANES*DATA_WIDTH-1:0] data_in,
    output logic                          in_ready,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic                          valid_out,
    output logic [LANE_W-1:0]             lane_out,
    output logic                          frame_end,
    input  logic                          out_ready
);
    typedef enum logic {IDLE, DRAIN} state_t;

    state_t                  state, state_nx;
    logic [DATA_WIDTH-1:0]   frame_q [N_LANES];
    logic [N_LANES-1:0]      mask_q;
    logic                    compact_q;
    logic [LANE_W-1:0]       ptr_q, ptr_nx;
    logic [LANE_W-1:0]       first_ptr, above_ptr;
    logic                    has_above, is_last, drain, advance, capture;

    // Lowest set bit of the incoming valids, and lowest mask bit above the pointer.
    always_comb begin
        first_ptr = '0;
        above_ptr = '0;
        has_above = 1'b0;
        for (int i = N_LANES - 1; i >= 0; i--) begin
            if (valid_in[i])
                first_ptr = LANE_W'(i);
            if (mask_q[i] && LANE_W'(i) > ptr_q) begin
                above_ptr = LANE_W'(i);
                has_above = 1'b1;
            end
        end
    end

    assign drain     = (state == DRAIN);
    assign is_last   = compact_q ? !has_above : (ptr_q == LANE_W'(N_LANES - 1));
    assign valid_out = drain && mask_q[ptr_q];
    assign data_out  = valid_out ? frame_q[ptr_q] : '0;
    assign lane_out  = drain ? ptr_q : '0;
    assign frame_end = drain && is_last;
    assign advance   = drain && (out_ready || !valid_out);
    assign in_ready  = reset_L && (!drain || (advance && is_last));
    assign capture   = in_ready && |valid_in;

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr_q;
        if (capture) begin
            state_nx = DRAIN;
            ptr_nx   = mode_compact ? first_ptr : '0;
        end else if (advance && is_last) begin
            state_nx = IDLE;
            ptr_nx   = '0;
        end else if (advance) begin
            ptr_nx   = compact_q ? above_ptr : ptr_q + LANE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state     <= IDLE;
            ptr_q     <= '0;
            mask_q    <= '0;
            compact_q <= 1'b0;
            for (int i = 0; i < N_LANES; i++)
                frame_q[i] <= '0;
        end else begin
            state <= state_nx;
            ptr_q <= ptr_nx;
            if (capture) begin
                mask_q    <= valid_in;
                compact_q <= mode_compact;
                for (int i = 0; i < N_LANES; i++)
                    frame_q[i] <= data_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end
endmodule

// File: tb/tb_lane_interleaver.sv
// tb_lane_interleaver: directed checks of lane_interleaver with hand-computed slot sequences.
module tb_lane_interleaver;
    logic        clk = 1'b0;
    logic        reset_L;
    logic        mode_compact;
    logic [3:0]  valid_in;
    logic [31:0] data_in;
    logic        in_ready;
    logic [7:0]  data_out;
    logic        valid_out;
    logic [1:0]  lane_out;
    logic        frame_end;
    logic        out_ready;

    int n_cmp = 0;
    int n_err = 0;

    lane_interleaver #(.DATA_WIDTH(8), .N_LANES(4)) dut (
        .clk          (clk),
        .reset_L      (reset_L),
        .mode_compact (mode_compact),
        .valid_in     (valid_in),
        .data_in      (data_in),
        .in_ready     (in_ready),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .lane_out     (lane_out),
        .frame_end    (frame_end),
        .out_ready    (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic slot(input string tag, input logic [7:0] d, input logic v,
                        input logic [1:0] l, input logic fe, input logic ir);
        #1;
        check({tag, ".data"}, 32'(data_out), 32'(d));
        check({tag, ".valid"}, 32'(valid_out), 32'(v));
        check({tag, ".lane"}, 32'(lane_out), 32'(l));
        check({tag, ".fend"}, 32'(frame_end), 32'(fe));
        check({tag, ".in_ready"}, 32'(in_ready), 32'(ir));
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    initial begin
        // Reset held with busy inputs
        reset_L = 1'b0; mode_compact = 1'b0; valid_in = 4'hF; data_in = 32'hDEADBEEF; out_ready = 1'b1;
        tick; tick; tick;
        slot("rst_hold", 8'h00, 1'b0, 2'd0, 1'b0, 1'b0);
        valid_in = 4'h0;
        reset_L  = 1'b1;
        slot("rst_rel", 8'h00, 1'b0, 2'd0, 1'b0, 1'b1);
        tick;
        slot("idle_nocap", 8'h00, 1'b0, 2'd0, 1'b0, 1'b1);

        // Full frame, all lanes valid
        data_in = 32'h44332211; valid_in = 4'hF;
        tick; valid_in = 4'h0;
        slot("f0", 8'h11, 1'b1, 2'd0, 1'b0, 1'b0);
        tick; slot("f1", 8'h22, 1'b1, 2'd1, 1'b0, 1'b0);
        tick; slot("f2", 8'h33, 1'b1, 2'd2, 1'b0, 1'b0);
        tick; slot("f3", 8'h44, 1'b1, 2'd3, 1'b1, 1'b1);
        tick; slot("f_idle", 8'h00, 1'b0, 2'd0, 1'b0, 1'b1);

        // Full frame with holes; invalid slots advance even without out_ready
        data_in = 32'h00CC00AA; valid_in = 4'b0101;
        tick; valid_in = 4'h0;
        slot("h0", 8'hAA, 1'b1, 2'd0, 1'b0, 1'b0);
        tick; slot("h1", 8'h00, 1'b0, 2'd1, 1'b0, 1'b0);
        out_ready = 1'b0;
        tick; slot("h2_hold", 8'hCC, 1'b1, 2'd2, 1'b0, 1'b0);
        tick; slot("h2_hold2", 8'hCC, 1'b1, 2'd2, 1'b0, 1'b0);
        out_ready = 1'b1;
        tick; slot("h3", 8'h00, 1'b0, 2'd3, 1'b1, 1'b1);
        tick; slot("h_idle", 8'h00, 1'b0, 2'd0, 1'b0, 1'b1);

        // Compact frame; mode flip after capture must not matter
        data_in = 32'h44002200; valid_in = 4'b1010; mode_compact = 1'b1;
        tick; valid_in = 4'h0; mode_compact = 1'b0;
        slot("c0", 8'h22, 1'b1, 2'd1, 1'b0, 1'b0);
        tick; slot("c1", 8'h44, 1'b1, 2'd3, 1'b1, 1'b1);
        tick; slot("c_idle", 8'h00, 1'b0, 2'd0, 1'b0, 1'b1);

        // Compact single-lane frame
        data_in = 32'h00770000; valid_in = 4'b0100; mode_compact = 1'b1;
        tick; valid_in = 4'h0; mode_compact = 1'b0;
        slot("s0", 8'h77, 1'b1, 2'd2, 1'b1, 1'b1);
        tick; slot("s_idle", 8'h00, 1'b0, 2'd0, 1'b0, 1'b1);

        // Backpressure on lane 1, then back-to-back frame
        data_in = 32'h44332211; valid_in = 4'hF;
        tick; valid_in = 4'h0;
        slot("b0", 8'h11, 1'b1, 2'd0, 1'b0, 1'b0);
        tick; out_ready = 1'b0;
        slot("b1_a", 8'h22, 1'b1, 2'd1, 1'b0, 1'b0);
        tick; slot("b1_b", 8'h22, 1'b1, 2'd1, 1'b0, 1'b0);
        tick; slot("b1_c", 8'h22, 1'b1, 2'd1, 1'b0, 1'b0);
        tick; out_ready = 1'b1;
        slot("b1_d", 8'h22, 1'b1, 2'd1, 1'b0, 1'b0);
        tick; slot("b2", 8'h33, 1'b1, 2'd2, 1'b0, 1'b0);
        data_in = 32'h88776655; valid_in = 4'hF;
        tick; slot("b3", 8'h44, 1'b1, 2'd3, 1'b1, 1'b1);
        tick; valid_in = 4'h0;
        slot("n0", 8'h55, 1'b1, 2'd0, 1'b0, 1'b0);
        tick; slot("n1", 8'h66, 1'b1, 2'd1, 1'b0, 1'b0);

        // Asynchronous reset mid-frame
        reset_L = 1'b0;
        slot("mid_rst", 8'h00, 1'b0, 2'd0, 1'b0, 1'b0);
        tick; reset_L = 1'b1;
        slot("post_rst", 8'h00, 1'b0, 2'd0, 1'b0, 1'b1);
        tick; slot("post_rst2", 8'h00, 1'b0, 2'd0, 1'b0, 1'b1);
        tick; slot("post_rst3", 8'h00, 1'b0, 2'd0, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
